// File: rtl/image_pkg.sv
// rtl/image_pkg.sv - shared image geometry and row-writer FSM encoding
package image_pkg;

    localparam int IMG_ROWS   = 64;
    localparam int ROW_W      = 64;
    localparam int WORD_W     = 32;
    localparam int RAM_ADDR_W = 7;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } wr_state_t;

endpackage

// File: rtl/row_fifo.sv
// rtl/row_fifo.sv - small synchronous row FIFO with sync clear
module row_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clear_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/edge_row_writer.sv
// rtl/edge_row_writer.sv - buffers processed rows and writes them as word pairs into the frame RAM
module edge_row_writer
    import image_pkg::*;
#(
    parameter int ROWS       = IMG_ROWS,
    parameter int ROW_W      = image_pkg::ROW_W,
    parameter int WORD_W     = image_pkg::WORD_W,
    parameter int ADDR_W     = RAM_ADDR_W,
    parameter int FIFO_DEPTH = image_pkg::FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              row_valid,
    input  logic [ROW_W-1:0]  row_data,
    output logic              row_ready,
    input  logic              frame_start,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              frame_done,
    output logic              overflow,
    output logic              busy
);

    localparam int ROW_CNT_W = $clog2(ROWS);

    logic                 fifo_full, fifo_empty, push, pop;
    logic [ROW_W-1:0]     fifo_rd;
    wr_state_t            state_q;
    logic [ROW_CNT_W-1:0] row_q, row_d;
    logic [WORD_W-1:0]    hold_hi_q;
    logic                 ne_q;

    assign row_ready = reset && !fifo_full && !frame_start;
    assign push      = row_valid && row_ready;
    // IDLE only starts a row once the FIFO has been non-empty for a full cycle,
    // so a back-to-back pair fills the buffer; HI chains straight into the next row.
    assign pop       = reset && !frame_start && !fifo_empty &&
                       ((state_q == ST_IDLE && ne_q) || state_q == ST_HI);
    assign row_d     = (row_q == ROW_CNT_W'(ROWS - 1)) ? '0 : row_q + 1'b1;
    assign busy      = !fifo_empty || (state_q != ST_IDLE);

    row_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ROW_W)
    ) u_row_fifo (
        .clk         (clk),
        .resetn      (reset),
        .clear_i     (frame_start),
        .push_i      (push),
        .push_data_i (row_data),
        .pop_i       (pop),
        .pop_data_o  (fifo_rd),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            hold_hi_q  <= '0;
            ne_q       <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else if (frame_start) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            ne_q       <= 1'b0;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            ne_q       <= !fifo_empty;
            frame_done <= 1'b0;
            if (row_valid && !row_ready) begin
                overflow <= 1'b1;
            end
            case (state_q)
                ST_IDLE, ST_HI: begin
                    if (pop) begin
                        hold_hi_q <= fifo_rd[ROW_W-1:WORD_W];
                        state_q   <= ST_LO;
                        wr_en     <= 1'b1;
                        wr_addr   <= ADDR_W'({row_q, 1'b0});
                        wr_data   <= fifo_rd[WORD_W-1:0];
                    end else begin
                        state_q <= ST_IDLE;
                        wr_en   <= 1'b0;
                    end
                end
                ST_LO: begin
                    state_q    <= ST_HI;
                    wr_en      <= 1'b1;
                    wr_addr    <= ADDR_W'({row_q, 1'b1});
                    wr_data    <= hold_hi_q;
                    frame_done <= (row_q == ROW_CNT_W'(ROWS - 1));
                    row_q      <= row_d;
                end
                default: begin
                    state_q <= ST_IDLE;
                    wr_en   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_row_writer.sv
// tb/tb_edge_row_writer.sv - scoreboard bench for edge_row_writer
module tb_edge_row_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        row_valid;
    logic [63:0] row_data;
    logic        row_ready;
    logic        frame_start;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic        frame_done;
    logic        overflow;
    logic        busy;

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
        logic        fd;
    } wr_exp_t;

    wr_exp_t sb[$];
    int      checks = 0;
    int      errors = 0;
    int      model_row = 0;

    always #5 clk = ~clk;

    edge_row_writer dut (
        .clk         (clk),
        .reset       (reset),
        .row_valid   (row_valid),
        .row_data    (row_data),
        .row_ready   (row_ready),
        .frame_start (frame_start),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every write seen on the RAM port must match the next scoreboard entry.
    always @(negedge clk) begin
        if (reset) begin
            if (wr_en) begin
                if (sb.size() == 0) begin
                    check("spurious_wr", {57'd0, wr_addr}, 64'h7f_dead);
                end else begin
                    wr_exp_t e;
                    e = sb.pop_front();
                    check("wr_addr", 64'(wr_addr), 64'(e.addr));
                    check("wr_data", 64'(wr_data), 64'(e.data));
                    check("frame_done", 64'(frame_done), 64'(e.fd));
                end
            end else begin
                check("frame_done_idle", 64'(frame_done), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [63:0] d, input logic exp_acc);
        wr_exp_t e;
        row_valid = 1'b1;
        row_data  = d;
        #1;
        check("row_ready", 64'(row_ready), 64'(exp_acc));
        @(posedge clk);
        #1;
        row_valid = 1'b0;
        if (exp_acc) begin
            e.addr = 7'(2 * model_row);
            e.data = d[31:0];
            e.fd   = 1'b0;
            sb.push_back(e);
            e.addr = 7'(2 * model_row + 1);
            e.data = d[63:32];
            e.fd   = (model_row == 63);
            sb.push_back(e);
            model_row = (model_row + 1) % 64;
        end
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        sb.delete();
        model_row = 0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 64; i++) begin
            if (sb.size() == 0 && !busy) break;
            tick();
        end
        check("drain_queue", 64'(sb.size()), 64'd0);
        check("drain_busy", 64'(busy), 64'd0);
    endtask

    task automatic wait_addr(input logic [6:0] a);
        bit found = 0;
        for (int i = 0; i < 64; i++) begin
            if (wr_en && wr_addr == a) begin
                found = 1;
                break;
            end
            tick();
        end
        check("wait_addr", 64'(found), 64'd1);
    endtask

    initial begin
        reset       = 1'b0;
        row_valid   = 1'b0;
        row_data    = '0;
        frame_start = 1'b0;
        tick();
        tick();
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_row_ready", 64'(row_ready), 64'd0);
        reset = 1'b1;
        #1;

        // Single row: exact latency and busy release.
        send_row(64'h0123_4567_89AB_CDEF, 1'b1);
        check("lat_n0", 64'(wr_en), 64'd0);
        tick();
        check("lat_n1", 64'(wr_en), 64'd0);
        tick();
        check("lat_lo_en", 64'(wr_en), 64'd1);
        check("lat_lo_addr", 64'(wr_addr), 64'd0);
        tick();
        check("lat_hi_addr", 64'(wr_addr), 64'd1);
        tick();
        check("lat_done_en", 64'(wr_en), 64'd0);
        check("lat_done_busy", 64'(busy), 64'd0);

        // Three consecutive strobes: third dropped, two rows with no bubble.
        pulse_frame_start();
        send_row(64'hAAAA_0001_5555_0000, 1'b1);
        send_row(64'hAAAA_0003_5555_0002, 1'b1);
        send_row(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        check("ovf_set", 64'(overflow), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check("no_bubble", 64'(wr_en), 64'd1);
            tick();
        end
        check("burst_end", 64'(wr_en), 64'd0);
        wait_drain();

        // Full frame spaced two cycles, then wrap.
        pulse_frame_start();
        check("ovf_clr_fs", 64'(overflow), 64'd0);
        for (int r = 0; r < 65; r++) begin
            send_row({32'(r) ^ 32'hC0DE_0000, $urandom()}, 1'b1);
            tick();
        end
        wait_drain();

        // frame_start mid-row abandons the high word.
        pulse_frame_start();
        send_row(64'h1111_1111_0000_0000, 1'b1);
        send_row(64'h1111_1111_0000_0001, 1'b1);
        send_row(64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
        tick();
        tick();
        for (int r = 2; r < 10; r++) begin
            send_row({32'h2222_0000 + 32'(r), $urandom()}, 1'b1);
            tick();
        end
        wait_addr(7'd18);
        pulse_frame_start();
        check("fs_wr_en", 64'(wr_en), 64'd0);
        check("fs_overflow", 64'(overflow), 64'd0);
        tick();
        check("fs_no_hi", 64'(wr_en), 64'd0);
        send_row(64'h3333_4444_5555_6666, 1'b1);
        wait_drain();

        // frame_start and row_valid together: row ignored, no overflow.
        row_valid   = 1'b1;
        row_data    = 64'h7777_7777_7777_7777;
        frame_start = 1'b1;
        #1;
        check("fs_rv_ready", 64'(row_ready), 64'd0);
        tick();
        row_valid   = 1'b0;
        frame_start = 1'b0;
        sb.delete();
        model_row = 0;
        check("fs_rv_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 4; i++) tick();
        check("fs_rv_busy", 64'(busy), 64'd0);

        // Reset during the low-word write.
        send_row(64'h8888_9999_AAAA_BBBB, 1'b1);
        wait_addr(7'd0);
        reset = 1'b0;
        #1;
        check("rst_mid_ready", 64'(row_ready), 64'd0);
        tick();
        check("rst_mid_en", 64'(wr_en), 64'd0);
        check("rst_mid_addr", 64'(wr_addr), 64'd0);
        check("rst_mid_data", 64'(wr_data), 64'd0);
        check("rst_mid_fd", 64'(frame_done), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        sb.delete();
        model_row = 0;
        tick();
        check("rst_mid_after", 64'(wr_en), 64'd0);
        send_row(64'hCAFE_F00D_1234_5678, 1'b1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
